// File: rtl/step_controller_if.sv
// rtl/step_controller_if.sv - control/status bundle between the board inputs and step_controller
// master drives the raw inputs and observes status; slave is the controller itself.
interface step_controller_if #(
  parameter int COUNT_W = 16
);
  logic               tick_in;
  logic               btn_step;
  logic               run_sw;
  logic               bp_en;
  logic [COUNT_W-1:0] bp_count;
  logic               cpu_en;
  logic [COUNT_W-1:0] step_count;
  logic [1:0]         state_out;
  logic               halted;

  modport master (
    output tick_in, btn_step, run_sw, bp_en, bp_count,
    input  cpu_en, step_count, state_out, halted
  );

  modport slave (
    input  tick_in, btn_step, run_sw, bp_en, bp_count,
    output cpu_en, step_count, state_out, halted
  );
endinterface

// File: rtl/step_controller.sv
// rtl/step_controller.sv - run/halt/single-step controller emitting one-cycle cpu_en pulses
// Optional step-count breakpoint enabled by defining STEP_CTRL_BREAKPOINT_EN.
module step_controller #(
  parameter int COUNT_W         = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic         clk_in,
  input logic         reset,
  step_controller_if.slave ctrl
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);

  state_t             state_q;
  state_t             state_n;
  logic               tick_d;
  logic               tick_armed;
  logic               tick_rise;
  logic               btn_s1;
  logic               btn_s2;
  logic               btn_deb;
  logic               btn_deb_d;
  logic [DB_W-1:0]    db_cnt;
  logic               step_press;
  logic               issue;
  logic               bp_hit;
  logic               cpu_en_q;
  logic [COUNT_W-1:0] step_count_q;
  logic [COUNT_W-1:0] step_next;
  logic [1:0]         state_out_c;
  logic               halted_c;

  // tick_d alone cannot tell a sampled 0 from the reset value, so a rise
  // also requires that tick_in has been seen low since reset.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_d     <= 1'b0;
      tick_armed <= 1'b0;
    end else begin
      tick_d     <= ctrl.tick_in;
      tick_armed <= tick_armed | ~ctrl.tick_in;
    end
  end

  assign tick_rise = ctrl.tick_in & ~tick_d & tick_armed;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_deb   <= 1'b0;
      btn_deb_d <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= ctrl.btn_step;
      btn_s2    <= btn_s1;
      btn_deb_d <= btn_deb;
      if (db_cnt == DB_LIMIT) begin
        btn_deb <= ~btn_deb;
        db_cnt  <= '0;
      end else if (btn_s2 != btn_deb) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_press = btn_deb & ~btn_deb_d;
  assign step_next  = step_count_q + 1'b1;

`ifdef STEP_CTRL_BREAKPOINT_EN
  assign bp_hit = ctrl.bp_en & (step_next == ctrl.bp_count);
`else
  logic bp_unused;
  assign bp_unused = ^{ctrl.bp_en, ctrl.bp_count};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_HALT: begin
        if (ctrl.run_sw) begin
          state_n = ST_RUN;
        end else if (step_press) begin
          state_n = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!ctrl.run_sw) begin
          state_n = ST_HALT;
        end else if (issue && bp_hit) begin
          state_n = ST_BREAK;
        end
      end
      ST_STEP: begin
        if (tick_rise) begin
          state_n = ST_HALT;
        end
      end
      ST_BREAK: begin
        // A step press out of BREAK wins over a simultaneous run_sw drop.
        if (step_press) begin
          state_n = ST_STEP;
        end else if (!ctrl.run_sw) begin
          state_n = ST_HALT;
        end
      end
      default: state_n = ST_HALT;
    endcase
  end

  always_comb begin
    issue       = tick_rise & ((state_q == ST_RUN) | (state_q == ST_STEP));
    state_out_c = state_q;
    halted_c    = (state_q != ST_RUN);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      cpu_en_q <= issue;
      if (issue) begin
        step_count_q <= step_next;
      end
    end
  end

  assign ctrl.cpu_en     = cpu_en_q;
  assign ctrl.step_count = step_count_q;
  assign ctrl.state_out  = state_out_c;
  assign ctrl.halted     = halted_c;

endmodule
